// File: rtl/pic_command_sequencer.sv
// 8259A-style command sequencer: synchronises CPU strobes, walks ICW1..ICW4, decodes OCW1..OCW3.
// Optional poll mode is compiled in with `define PIC_POLL_EN.

module pic_cmd_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= {STAGES{RST_VAL}};
    else       vld_pipe <= {vld_pipe[STAGES-2:0], d};
  end

  assign q = vld_pipe[STAGES-1];
endmodule

module pic_command_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_IRQ     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chip_select_bar,
  input  logic               read_bar,
  input  logic               write_bar,
  input  logic               A0,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               data_out_en,
  input  logic [NUM_IRQ-1:0] irr_in,
  input  logic [NUM_IRQ-1:0] isr_in,
  output logic               ICW_1_flag,
  output logic               ICW_2_flag,
  output logic               ICW_3_flag,
  output logic               ICW_4_flag,
  output logic               OCW_1_flag,
  output logic               OCW_2_flag,
  output logic               OCW_3_flag,
  output logic               write_ignored,
  output logic               init_done,
  output logic               ltim,
  output logic               sngl,
  output logic               ic4,
  output logic [4:0]         vector_base,
  output logic [7:0]         cascade_cfg,
  output logic               upm,
  output logic               aeoi,
  output logic               ms,
  output logic               buf_mode,
  output logic               sfnm,
  output logic [NUM_IRQ-1:0] imr,
  output logic [7:0]         ocw2_cmd,
  output logic               ris,
  output logic               smm,
  output logic               poll_ack
);
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

  // Strobe lanes {a0, wr, rd, cs}; the active-low strobes idle high out of reset
  // so no phantom edge appears on release.
  localparam logic [3:0] SYNC_RST = 4'b0110;

  logic [3:0] raw, syn;
  logic       cs_s, rd_s, wr_s, a0_s;

  assign raw = {A0, write_bar, read_bar, chip_select_bar};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    pic_cmd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[gi])) u_sync (
      .clk(clk), .reset(reset), .d(raw[gi]), .q(syn[gi]));
  end

  assign cs_s = syn[0];
  assign rd_s = syn[1];
  assign wr_s = syn[2];
  assign a0_s = syn[3];

  // Write capture and commit detect
  logic       wr_s_q, wr_seen, wr_a0, commit;
  logic [7:0] wr_data;

  assign commit = wr_s & ~wr_s_q & wr_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_s_q  <= 1'b1;
      wr_seen <= 1'b0;
      wr_a0   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_s_q <= wr_s;
      if (!cs_s && !wr_s) begin
        wr_seen <= 1'b1;
        wr_a0   <= a0_s;
        wr_data <= data_in;
      end else if (commit) begin
        wr_seen <= 1'b0;
      end
    end
  end

  // Init FSM and command decode
  state_t state, state_nxt;
  logic   do_icw1, do_icw2, do_icw3, do_icw4, do_ocw1, do_ocw2, do_ocw3, do_ign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_icw1 = 1'b0; do_icw2 = 1'b0; do_icw3 = 1'b0; do_icw4 = 1'b0;
    do_ocw1 = 1'b0; do_ocw2 = 1'b0; do_ocw3 = 1'b0; do_ign  = 1'b0;
    if (commit) begin
      if (!wr_a0) begin
        if (wr_data[4]) begin
          do_icw1   = 1'b1;
          state_nxt = WAIT_ICW2;
        end else if (state != READY) begin
          do_ign = 1'b1;
        end else if (wr_data[3]) begin
          do_ocw3 = 1'b1;
        end else begin
          do_ocw2 = 1'b1;
        end
      end else begin
        case (state)
          IDLE: do_ign = 1'b1;
          WAIT_ICW2: begin
            do_icw2   = 1'b1;
            state_nxt = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: begin
            do_icw3   = 1'b1;
            state_nxt = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            do_icw4   = 1'b1;
            state_nxt = READY;
          end
          READY:   do_ocw1 = 1'b1;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign init_done = (state == READY);

  // Configuration registers and commit pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ICW_1_flag <= 1'b0; ICW_2_flag <= 1'b0; ICW_3_flag <= 1'b0; ICW_4_flag <= 1'b0;
      OCW_1_flag <= 1'b0; OCW_2_flag <= 1'b0; OCW_3_flag <= 1'b0;
      write_ignored <= 1'b0;
      ltim <= 1'b0; sngl <= 1'b0; ic4 <= 1'b0;
      vector_base <= '0;
      cascade_cfg <= '0;
      upm <= 1'b0; aeoi <= 1'b0; ms <= 1'b0; buf_mode <= 1'b0; sfnm <= 1'b0;
      imr <= '0;
      ocw2_cmd <= '0;
      ris <= 1'b0;
      smm <= 1'b0;
    end else begin
      ICW_1_flag <= do_icw1; ICW_2_flag <= do_icw2; ICW_3_flag <= do_icw3; ICW_4_flag <= do_icw4;
      OCW_1_flag <= do_ocw1; OCW_2_flag <= do_ocw2; OCW_3_flag <= do_ocw3;
      write_ignored <= do_ign;
      if (do_icw1) begin
        ltim <= wr_data[3];
        sngl <= wr_data[1];
        ic4  <= wr_data[0];
        upm <= 1'b0; aeoi <= 1'b0; ms <= 1'b0; buf_mode <= 1'b0; sfnm <= 1'b0;
        imr <= '0;
        ris <= 1'b0;
        smm <= 1'b0;
      end
      if (do_icw2) vector_base <= wr_data[7:3];
      if (do_icw3) cascade_cfg <= wr_data;
      if (do_icw4) begin
        upm      <= wr_data[0];
        aeoi     <= wr_data[1];
        ms       <= wr_data[2];
        buf_mode <= wr_data[3];
        sfnm     <= wr_data[4];
      end
      if (do_ocw1) imr <= wr_data[NUM_IRQ-1:0];
      if (do_ocw2) ocw2_cmd <= wr_data;
      if (do_ocw3) begin
        if (wr_data[1]) ris <= wr_data[0];
        if (wr_data[6]) smm <= wr_data[5];
      end
    end
  end

  // Read-back: zero-extend the NUM_IRQ-wide sources to the byte bus
  logic [7:0] rd_imr, rd_irr, rd_isr, rd_mux;

  always_comb begin
    rd_imr = '0;
    rd_irr = '0;
    rd_isr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      rd_imr[i] = imr[i];
      rd_irr[i] = irr_in[i];
      rd_isr[i] = isr_in[i];
    end
    rd_mux = a0_s ? rd_imr : (ris ? rd_isr : rd_irr);
  end

`ifdef PIC_POLL_EN
  logic               poll_armed, rd_s_q, rd_seen, rd_a0, rd_rise, poll_int;
  logic [2:0]         poll_w;
  logic [NUM_IRQ-1:0] pend;

  assign rd_rise = rd_s & ~rd_s_q;

  always_comb begin
    pend     = irr_in & ~imr;
    poll_int = |pend;
    poll_w   = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (pend[i]) poll_w = 3'(i);
    data_out = (poll_armed && !a0_s) ? {poll_int, 4'b0000, poll_w} : rd_mux;
  end

  // A read only counts if it was not overlapped by a write (write wins)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_s_q     <= 1'b1;
      rd_seen    <= 1'b0;
      rd_a0      <= 1'b0;
      poll_armed <= 1'b0;
      poll_ack   <= 1'b0;
    end else begin
      rd_s_q   <= rd_s;
      poll_ack <= 1'b0;
      if (!cs_s && !rd_s && wr_s) begin
        rd_seen <= 1'b1;
        rd_a0   <= a0_s;
      end else if (rd_rise) begin
        rd_seen <= 1'b0;
      end
      if (do_icw1) begin
        poll_armed <= 1'b0;
      end else if (do_ocw3 && wr_data[2]) begin
        poll_armed <= 1'b1;
      end else if (rd_rise && rd_seen && !rd_a0 && poll_armed) begin
        poll_armed <= 1'b0;
        poll_ack   <= poll_int;
      end
    end
  end
`else
  logic unused_rd;

  assign unused_rd = rd_s;
  assign data_out  = rd_mux;
  assign poll_ack  = 1'b0;
`endif

  assign data_out_en = !chip_select_bar & !read_bar & write_bar;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed bench for pic_command_sequencer: init sequences, OCW decode, read-back,
// illegal writes, reset mid-write and (with PIC_POLL_EN) poll reads.

module tb_pic_command_sequencer;
  localparam int SYNC = 2;
  localparam int NIRQ = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            chip_select_bar, read_bar, write_bar, A0;
  logic [7:0]      data_in, data_out;
  logic            data_out_en;
  logic [NIRQ-1:0] irr_in, isr_in, imr;
  logic            ICW_1_flag, ICW_2_flag, ICW_3_flag, ICW_4_flag;
  logic            OCW_1_flag, OCW_2_flag, OCW_3_flag, write_ignored, init_done;
  logic            ltim, sngl, ic4, upm, aeoi, ms, buf_mode, sfnm, ris, smm, poll_ack;
  logic [4:0]      vector_base;
  logic [7:0]      cascade_cfg, ocw2_cmd;

  pic_command_sequencer #(.SYNC_STAGES(SYNC), .NUM_IRQ(NIRQ)) dut (
    .clk(clk), .reset(reset),
    .chip_select_bar(chip_select_bar), .read_bar(read_bar), .write_bar(write_bar), .A0(A0),
    .data_in(data_in), .data_out(data_out), .data_out_en(data_out_en),
    .irr_in(irr_in), .isr_in(isr_in),
    .ICW_1_flag(ICW_1_flag), .ICW_2_flag(ICW_2_flag), .ICW_3_flag(ICW_3_flag), .ICW_4_flag(ICW_4_flag),
    .OCW_1_flag(OCW_1_flag), .OCW_2_flag(OCW_2_flag), .OCW_3_flag(OCW_3_flag),
    .write_ignored(write_ignored), .init_done(init_done),
    .ltim(ltim), .sngl(sngl), .ic4(ic4), .vector_base(vector_base), .cascade_cfg(cascade_cfg),
    .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
    .imr(imr), .ocw2_cmd(ocw2_cmd), .ris(ris), .smm(smm), .poll_ack(poll_ack));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  // pulse counters: 0..3 ICW1..4, 4..6 OCW1..3, 7 write_ignored, 8 poll_ack
  int cnt [9];

  always @(negedge clk) begin
    if (ICW_1_flag)    cnt[0]++;
    if (ICW_2_flag)    cnt[1]++;
    if (ICW_3_flag)    cnt[2]++;
    if (ICW_4_flag)    cnt[3]++;
    if (OCW_1_flag)    cnt[4]++;
    if (OCW_2_flag)    cnt[5]++;
    if (OCW_3_flag)    cnt[6]++;
    if (write_ignored) cnt[7]++;
    if (poll_ack)      cnt[8]++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 9; i++) cnt[i] = 0;
  endtask

  task automatic bus_write(input logic a0, input logic [7:0] d);
    tick(1);
    A0 = a0; data_in = d; chip_select_bar = 1'b0;
    tick(1);
    write_bar = 1'b0;
    tick(4);
    write_bar = 1'b1;
    tick(1);
    chip_select_bar = 1'b1;
    tick(SYNC + 4);
  endtask

  task automatic read_start(input logic a0);
    tick(1);
    A0 = a0; chip_select_bar = 1'b0; read_bar = 1'b0;
    tick(SYNC + 2);
  endtask

  task automatic read_end();
    read_bar = 1'b1;
    tick(1);
    chip_select_bar = 1'b1;
    tick(SYNC + 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr_cnt();
    reset = 1'b1;
    chip_select_bar = 1'b1; read_bar = 1'b1; write_bar = 1'b1; A0 = 1'b0;
    data_in = '0; irr_in = '0; isr_in = '0;
    tick(3);
    chk("rst_bits", {ltim, sngl, ic4, upm, aeoi, ms, buf_mode, sfnm, ris, smm, init_done, poll_ack}, 0);
    chk("rst_regs", {vector_base, cascade_cfg, imr, ocw2_cmd}, 0);
    chk("rst_bus", {data_out, data_out_en}, 0);
    reset = 1'b0;
    tick(3);
    chk("rst_flags", cnt[0]+cnt[1]+cnt[2]+cnt[3]+cnt[4]+cnt[5]+cnt[6]+cnt[7], 0);

    // ICW1(single, ic4) -> ICW2 -> ICW4
    clr_cnt();
    bus_write(1'b0, 8'h13);
    chk("t1_icw1", cnt[0], 1);
    chk("t1_sngl_ic4", {sngl, ic4, ltim}, 3'b110);
    bus_write(1'b1, 8'h20);
    chk("t1_icw2", cnt[1], 1);
    chk("t1_vbase", vector_base, 5'h04);
    chk("t1_not_ready", init_done, 0);
    bus_write(1'b1, 8'h01);
    chk("t1_icw4", {cnt[2], cnt[3]}, {32'd0, 32'd1});
    chk("t1_upm", upm, 1);
    chk("t1_done", init_done, 1);

    // ICW1(cascade, no ic4) -> ICW2 -> ICW3, ICW4 skipped
    clr_cnt();
    bus_write(1'b0, 8'h10);
    chk("t2_icw1", cnt[0], 1);
    chk("t2_upm_clr", {upm, init_done}, 0);
    bus_write(1'b1, 8'h08);
    chk("t2_vbase", vector_base, 5'h01);
    bus_write(1'b1, 8'h04);
    chk("t2_icw3", cnt[2], 1);
    chk("t2_casc", cascade_cfg, 8'h04);
    chk("t2_no_icw4", cnt[3], 0);
    chk("t2_done", init_done, 1);

    // OCW1 and IMR read-back
    clr_cnt();
    bus_write(1'b1, 8'hA5);
    chk("t3_imr", imr, 8'hA5);
    chk("t3_ocw1", cnt[4], 1);
    chk("t3_en_idle", data_out_en, 0);
    read_start(1'b1);
    chk("t3_rd_data", data_out, 8'hA5);
    chk("t3_rd_en", data_out_en, 1);
    read_end();
    chk("t3_en_after", data_out_en, 0);
    chk("t3_ocw1_once", cnt[4], 1);

    // OCW2 in READY
    clr_cnt();
    bus_write(1'b0, 8'h20);
    chk("ocw2_flag", {cnt[5], cnt[7]}, {32'd1, 32'd0});
    chk("ocw2_cmd", ocw2_cmd, 8'h20);

    // OCW3 read select
    irr_in = 8'h0C; isr_in = 8'h04;
    clr_cnt();
    bus_write(1'b0, 8'h0B);
    chk("t4_ocw3", cnt[6], 1);
    chk("t4_ris", ris, 1);
    read_start(1'b0);
    chk("t4_isr", data_out, 8'h04);
    read_end();
    bus_write(1'b0, 8'h0A);
    read_start(1'b0);
    chk("t4_irr", data_out, 8'h0C);
    read_end();
    bus_write(1'b0, 8'h68);
    chk("t4_smm", {smm, ris}, 2'b10);

    // Simultaneous read and write: write wins
    tick(1);
    A0 = 1'b1; data_in = 8'h3C;
    chip_select_bar = 1'b0; read_bar = 1'b0; write_bar = 1'b0;
    tick(1);
    chk("rw_en", data_out_en, 0);
    tick(3);
    write_bar = 1'b1;
    tick(1);
    read_bar = 1'b1; chip_select_bar = 1'b1;
    tick(SYNC + 4);
    chk("rw_imr", imr, 8'h3C);

    // Poll command
    clr_cnt();
    bus_write(1'b1, 8'h01);
    irr_in = 8'h06;
    bus_write(1'b0, 8'h0C);
`ifdef PIC_POLL_EN
    read_start(1'b0);
    chk("t6_poll_data", data_out, 8'h81);
    read_end();
    chk("t6_poll_ack", cnt[8], 1);
    read_start(1'b0);
    chk("t6_after_poll", data_out, 8'h06);
    read_end();
    chk("t6_ack_once", cnt[8], 1);
`else
    read_start(1'b0);
    chk("t6_no_poll", data_out, 8'h06);
    read_end();
    chk("t6_no_ack", cnt[8], 0);
`endif

    // Illegal write in IDLE, then reset mid-ICW sequence
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    irr_in = '0; isr_in = '0;
    tick(2);
    clr_cnt();
    bus_write(1'b0, 8'h20);
    chk("t5_ignored", cnt[7], 1);
    chk("t5_no_ocw2", {cnt[5], 24'h0, ocw2_cmd}, 0);
    bus_write(1'b0, 8'h13);
    chk("t5_icw1", {ic4, sngl}, 2'b11);
    tick(1);
    A0 = 1'b1; data_in = 8'h20; chip_select_bar = 1'b0;
    tick(1);
    write_bar = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    write_bar = 1'b1; chip_select_bar = 1'b1;
    tick(2);
    reset = 1'b0;
    clr_cnt();
    tick(8);
    chk("t5_no_flags", cnt[0]+cnt[1]+cnt[2]+cnt[3]+cnt[4]+cnt[5]+cnt[6]+cnt[7]+cnt[8], 0);
    chk("t5_bits", {ltim, sngl, ic4, upm, aeoi, ms, buf_mode, sfnm, ris, smm, init_done}, 0);
    chk("t5_regs", {vector_base, cascade_cfg, imr, ocw2_cmd}, 0);
    chk("t5_bus", {data_out, data_out_en}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
